// File: rtl/raster_pkg.sv
// Shared raster types: default geometry, coordinate/pixel types, box record and scan states.
package raster_pkg;

    localparam int COORD_W  = 11;
    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 600;

    typedef logic signed [COORD_W-1:0] coord_s;
    typedef logic        [COORD_W-1:0] pixel_t;

    typedef struct packed {
        pixel_t xmin;
        pixel_t xmax;
        pixel_t ymin;
        pixel_t ymax;
    } bbox_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SCAN
    } scan_state_e;

endpackage

// File: rtl/bbox_clip.sv
// Combinational bounding box of three signed vertices, clipped to the screen, with an empty flag.
// Arithmetic is done one bit wider than the coordinates so that off-screen vertices compare correctly.
module bbox_clip #(
    parameter int COORD_W  = raster_pkg::COORD_W,
    parameter int SCREEN_W = raster_pkg::SCREEN_W,
    parameter int SCREEN_H = raster_pkg::SCREEN_H
) (
    input  logic signed [COORD_W-1:0] v0_x_i,
    input  logic signed [COORD_W-1:0] v0_y_i,
    input  logic signed [COORD_W-1:0] v1_x_i,
    input  logic signed [COORD_W-1:0] v1_y_i,
    input  logic signed [COORD_W-1:0] v2_x_i,
    input  logic signed [COORD_W-1:0] v2_y_i,
    output raster_pkg::bbox_t         box_o,
    output logic                      empty_o
);
    import raster_pkg::*;

    localparam logic signed [COORD_W:0] ZERO  = '0;
    localparam logic signed [COORD_W:0] X_LIM = (COORD_W+1)'(SCREEN_W - 1);
    localparam logic signed [COORD_W:0] Y_LIM = (COORD_W+1)'(SCREEN_H - 1);

    logic signed [COORD_W:0] ax, bx, cx, ay, by, cy;
    logic signed [COORD_W:0] min_x, max_x, min_y, max_y;
    logic signed [COORD_W:0] xlo, xhi, ylo, yhi;

    // Three-way signed min/max, then clamp to the visible screen rectangle.
    always_comb begin
        ax = (COORD_W+1)'(v0_x_i);
        bx = (COORD_W+1)'(v1_x_i);
        cx = (COORD_W+1)'(v2_x_i);
        ay = (COORD_W+1)'(v0_y_i);
        by = (COORD_W+1)'(v1_y_i);
        cy = (COORD_W+1)'(v2_y_i);

        min_x = ax;
        max_x = ax;
        if (bx < min_x) min_x = bx;
        if (cx < min_x) min_x = cx;
        if (bx > max_x) max_x = bx;
        if (cx > max_x) max_x = cx;

        min_y = ay;
        max_y = ay;
        if (by < min_y) min_y = by;
        if (cy < min_y) min_y = cy;
        if (by > max_y) max_y = by;
        if (cy > max_y) max_y = cy;

        xlo = (min_x < ZERO)  ? ZERO  : min_x;
        xhi = (max_x > X_LIM) ? X_LIM : max_x;
        ylo = (min_y < ZERO)  ? ZERO  : min_y;
        yhi = (max_y > Y_LIM) ? Y_LIM : max_y;

        empty_o = (xlo > xhi) || (ylo > yhi);

        box_o.xmin = xlo[COORD_W-1:0];
        box_o.xmax = xhi[COORD_W-1:0];
        box_o.ymin = ylo[COORD_W-1:0];
        box_o.ymax = yhi[COORD_W-1:0];
    end

endmodule

// File: rtl/bbox_pixel_scanner.sv
// Accepts one triangle, computes its screen-clipped bounding box and streams every pixel of the
// box in row-major order over a valid/ready interface. All outputs are registered.
module bbox_pixel_scanner #(
    parameter int COORD_W  = raster_pkg::COORD_W,
    parameter int SCREEN_W = raster_pkg::SCREEN_W,
    parameter int SCREEN_H = raster_pkg::SCREEN_H
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [COORD_W-1:0] v0_x,
    input  logic [COORD_W-1:0] v0_y,
    input  logic [COORD_W-1:0] v1_x,
    input  logic [COORD_W-1:0] v1_y,
    input  logic [COORD_W-1:0] v2_x,
    input  logic [COORD_W-1:0] v2_y,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               pix_last,
    output logic               tri_done
);
    import raster_pkg::*;

    scan_state_e state_q, state_d;

    logic signed [COORD_W-1:0] v0x_q, v0y_q, v1x_q, v1y_q, v2x_q, v2y_q;

    logic [COORD_W-1:0] xmin_q, xmin_d;
    logic [COORD_W-1:0] xmax_q, xmax_d;
    logic [COORD_W-1:0] ymax_q, ymax_d;
    logic [COORD_W-1:0] cur_x_q, cur_x_d;
    logic [COORD_W-1:0] cur_y_q, cur_y_d;
    logic [COORD_W-1:0] nxt_x, nxt_y;
    logic               last_q, last_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               accept;

    bbox_t clip_box;
    logic  clip_empty;

    assign accept = (state_q == IDLE) && tri_valid && ready_q;

    bbox_clip #(
        .COORD_W  (COORD_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clip (
        .v0_x_i  (v0x_q),
        .v0_y_i  (v0y_q),
        .v1_x_i  (v1x_q),
        .v1_y_i  (v1y_q),
        .v2_x_i  (v2x_q),
        .v2_y_i  (v2y_q),
        .box_o   (clip_box),
        .empty_o (clip_empty)
    );

    // Capture the triangle's vertices on the input handshake; SETUP works from these copies.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v0x_q <= '0;
            v0y_q <= '0;
            v1x_q <= '0;
            v1y_q <= '0;
            v2x_q <= '0;
            v2y_q <= '0;
        end else if (accept) begin
            v0x_q <= v0_x;
            v0y_q <= v0_y;
            v1x_q <= v1_x;
            v1y_q <= v1_y;
            v2x_q <= v2_x;
            v2y_q <= v2_y;
        end
    end

    // Next-state logic: box latch in SETUP, raster walk in SCAN, ready withheld while tri_done shows.
    always_comb begin
        state_d = state_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymax_d  = ymax_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        last_d  = last_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        nxt_x   = cur_x_q + 1'b1;
        nxt_y   = cur_y_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                xmin_d = clip_box.xmin;
                xmax_d = clip_box.xmax;
                ymax_d = clip_box.ymax;
                if (clip_empty) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cur_x_d = clip_box.xmin;
                    cur_y_d = clip_box.ymin;
                    last_d  = (clip_box.xmin == clip_box.xmax) && (clip_box.ymin == clip_box.ymax);
                    valid_d = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (valid_q && pix_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (cur_x_q < xmax_q) begin
                        cur_x_d = nxt_x;
                        last_d  = (nxt_x == xmax_q) && (cur_y_q == ymax_q);
                    end else begin
                        cur_x_d = xmin_q;
                        cur_y_d = nxt_y;
                        last_d  = (xmin_q == xmax_q) && (nxt_y == ymax_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        ready_d = (state_d == IDLE) && !done_d;
    end

    // State and output registers; async reset discards any in-flight triangle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymax_q  <= ymax_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign tri_ready = ready_q;
    assign pix_valid = valid_q;
    assign pixel_x   = cur_x_q;
    assign pixel_y   = cur_y_q;
    assign pix_last  = last_q;
    assign tri_done  = done_q;

endmodule

// File: tb/tb_bbox_pixel_scanner.sv
// Self-checking bench for bbox_pixel_scanner: a reference box model fills an expected-pixel
// queue when each triangle is driven, and every output handshake pops and compares one entry.
module tb_bbox_pixel_scanner;

    localparam int CW = 11;
    localparam int SW = 800;
    localparam int SH = 600;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          tri_valid;
    logic          tri_ready;
    logic [CW-1:0] v0_x, v0_y, v1_x, v1_y, v2_x, v2_y;
    logic          pix_valid;
    logic          pix_ready;
    logic [CW-1:0] pixel_x, pixel_y;
    logic          pix_last;
    logic          tri_done;

    typedef struct {
        int x;
        int y;
        int last;
    } pix_s;

    pix_s expQ[$];
    int   checks   = 0;
    int   failures = 0;

    bbox_pixel_scanner dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tri_valid (tri_valid),
        .tri_ready (tri_ready),
        .v0_x      (v0_x),
        .v0_y      (v0_y),
        .v1_x      (v1_x),
        .v1_y      (v1_y),
        .v2_x      (v2_x),
        .v2_y      (v2_y),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .pix_last  (pix_last),
        .tri_done  (tri_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Reference model: clipped box of the triangle, every pixel pushed in row-major order.
    function automatic int pushExpected(input int x0, input int y0, input int x1, input int y1,
                                        input int x2, input int y2);
        int xlo, xhi, ylo, yhi, n;
        pix_s p;
        xlo = min3(x0, x1, x2);
        xhi = max3(x0, x1, x2);
        ylo = min3(y0, y1, y2);
        yhi = max3(y0, y1, y2);
        if (xlo < 0) xlo = 0;
        if (ylo < 0) ylo = 0;
        if (xhi > SW - 1) xhi = SW - 1;
        if (yhi > SH - 1) yhi = SH - 1;
        n = 0;
        if (xlo > xhi || ylo > yhi) return 0;
        for (int y = ylo; y <= yhi; y++) begin
            for (int x = xlo; x <= xhi; x++) begin
                p.x    = x;
                p.y    = y;
                p.last = (x == xhi && y == yhi) ? 1 : 0;
                expQ.push_back(p);
                n++;
            end
        end
        return n;
    endfunction

    task automatic driveTri(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2);
        v0_x = CW'(x0);
        v0_y = CW'(y0);
        v1_x = CW'(x1);
        v1_y = CW'(y1);
        v2_x = CW'(x2);
        v2_y = CW'(y2);
    endtask

    // Runs one triangle end to end; stallMode 1 drives pix_ready as 1,0,0 repeating.
    task automatic applyStimulus(input string tag, input int x0, input int y0, input int x1,
                                 input int y1, input int x2, input int y2, input int stallMode);
        int            expN, cyc, got, lastHsCyc, guard;
        logic          stalled, rdy, hl;
        logic [CW-1:0] hx, hy;
        pix_s          e;

        expN  = pushExpected(x0, y0, x1, y1, x2, y2);
        guard = 0;
        while (tri_ready !== 1'b1 && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput({tag, "_ready_idle"}, tri_ready, 1);

        driveTri(x0, y0, x1, y1, x2, y2);
        tri_valid = 1'b1;
        @(posedge clk); #1;
        tri_valid = 1'b0;
        checkOutput({tag, "_setup_no_valid"}, pix_valid, 0);
        checkOutput({tag, "_setup_ready_low"}, tri_ready, 0);
        @(posedge clk); #1;

        if (expN == 0) begin
            checkOutput({tag, "_empty_done"}, tri_done, 1);
            checkOutput({tag, "_empty_no_valid"}, pix_valid, 0);
            checkOutput({tag, "_ready_low_on_done"}, tri_ready, 0);
        end else begin
            checkOutput({tag, "_first_valid_latency"}, pix_valid, 1);
            cyc       = 0;
            got       = 0;
            stalled   = 1'b0;
            lastHsCyc = -10;
            hx        = '0;
            hy        = '0;
            hl        = 1'b0;
            while (tri_done !== 1'b1 && cyc < expN * 4 + 20) begin
                checkOutput({tag, "_valid_until_done"}, pix_valid, 1);
                if (stalled) begin
                    checkOutput({tag, "_hold_x"}, pixel_x, hx);
                    checkOutput({tag, "_hold_y"}, pixel_y, hy);
                    checkOutput({tag, "_hold_last"}, pix_last, hl);
                end
                rdy       = (stallMode == 0) ? 1'b1 : ((cyc % 3) == 0);
                pix_ready = rdy;
                if (pix_valid === 1'b1 && rdy) begin
                    checkOutput({tag, "_queue_nonempty"}, (expQ.size() > 0), 1);
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        checkOutput({tag, "_pixel_x"}, pixel_x, e.x);
                        checkOutput({tag, "_pixel_y"}, pixel_y, e.y);
                        checkOutput({tag, "_pix_last"}, pix_last, e.last);
                    end
                    got++;
                    lastHsCyc = cyc;
                end
                stalled = (pix_valid === 1'b1) && !rdy;
                hx      = pixel_x;
                hy      = pixel_y;
                hl      = pix_last;
                @(posedge clk); #1;
                cyc++;
            end
            pix_ready = 1'b0;
            checkOutput({tag, "_done_seen"}, tri_done, 1);
            checkOutput({tag, "_pixel_count"}, got, expN);
            checkOutput({tag, "_queue_drained"}, expQ.size(), 0);
            checkOutput({tag, "_done_after_last"}, lastHsCyc, cyc - 1);
            checkOutput({tag, "_valid_off_on_done"}, pix_valid, 0);
            checkOutput({tag, "_ready_low_on_done"}, tri_ready, 0);
        end

        @(posedge clk); #1;
        checkOutput({tag, "_done_one_cycle"}, tri_done, 0);
        checkOutput({tag, "_ready_after_done"}, tri_ready, 1);
        expQ.delete();
    endtask

    initial begin
        pix_s e;
        int   n;

        reset_n   = 1'b0;
        tri_valid = 1'b0;
        pix_ready = 1'b0;
        driveTri(0, 0, 0, 0, 0, 0);

        #3;
        checkOutput("rst_tri_ready", tri_ready, 0);
        checkOutput("rst_pix_valid", pix_valid, 0);
        checkOutput("rst_pixel_x", pixel_x, 0);
        checkOutput("rst_pixel_y", pixel_y, 0);
        checkOutput("rst_pix_last", pix_last, 0);
        checkOutput("rst_tri_done", tri_done, 0);

        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkOutput("rst_release_ready_low", tri_ready, 0);
        @(posedge clk); #1;
        checkOutput("rst_release_ready_high", tri_ready, 1);

        applyStimulus("basic", 0, 0, 2, 0, 0, 1, 0);
        applyStimulus("stall", 0, 0, 2, 0, 0, 1, 1);
        applyStimulus("clip_neg", -5, -5, 1, -5, -5, 1, 0);
        applyStimulus("clip_pos", 798, 598, 900, 598, 798, 700, 1);
        applyStimulus("offscreen", 810, 10, 900, 10, 850, 50, 0);
        applyStimulus("single", 5, 7, 5, 7, 5, 7, 0);
        applyStimulus("column", 3, 4, 3, 6, 3, 5, 1);

        // Reset in the middle of a 100x100 scan.
        n = pushExpected(0, 0, 99, 0, 0, 99);
        checkOutput("big_model_count", n, 10000);
        driveTri(0, 0, 99, 0, 0, 99);
        tri_valid = 1'b1;
        @(posedge clk); #1;
        tri_valid = 1'b0;
        pix_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 150; i++) begin
            checkOutput("big_valid", pix_valid, 1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("big_pixel_x", pixel_x, e.x);
                checkOutput("big_pixel_y", pixel_y, e.y);
                checkOutput("big_pix_last", pix_last, e.last);
            end
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_pix_valid", pix_valid, 0);
        checkOutput("midrst_pixel_x", pixel_x, 0);
        checkOutput("midrst_pixel_y", pixel_y, 0);
        checkOutput("midrst_pix_last", pix_last, 0);
        checkOutput("midrst_tri_done", tri_done, 0);
        checkOutput("midrst_tri_ready", tri_ready, 0);
        expQ.delete();
        pix_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("midrst_hold_no_done", tri_done, 0);
            checkOutput("midrst_hold_no_valid", pix_valid, 0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_no_done_after", tri_done, 0);
        applyStimulus("after_rst", 10, 20, 12, 20, 10, 21, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
